// File: rtl/cursor_pkg.sv
// Shared constants and state encoding for the crosshair plotter.
package cursor_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    localparam logic [2:0] BG_COLOUR_DEFAULT = 3'b000;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StHoriz = 2'd1,
        StVert  = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/cursor_clip.sv
// Combinational on-screen test for a signed pixel coordinate.
module cursor_clip
    import cursor_pkg::*;
(
    input  logic signed [8:0] x_i,
    input  logic signed [7:0] y_i,
    output logic              on_screen_o
);

    // A clear sign bit makes the low bits the magnitude, so an unsigned compare suffices.
    assign on_screen_o = !x_i[8] && (x_i[7:0] < 8'(SCREEN_W)) &&
                         !y_i[7] && (y_i[6:0] < 7'(SCREEN_H));

endmodule

// File: rtl/cursor_plotter.sv
// Draws one clipped crosshair (horizontal arm then vertical arm) per accepted go request.
module cursor_plotter
    import cursor_pkg::*;
#(
    parameter int unsigned ARM       = 2,
    parameter logic [2:0]  BG_COLOUR = BG_COLOUR_DEFAULT
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       go,
    input  logic       erase,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [2:0] colour_in,
    output logic [7:0] x_VGA,
    output logic [6:0] y_VGA,
    output logic [2:0] colour,
    output logic       writeEn,
    output logic       busy,
    output logic       done
);

    localparam logic signed [3:0] ArmPos = 4'(ARM);
    localparam logic signed [3:0] ArmNeg = -ArmPos;

    state_e            state_q, state_d;
    logic signed [3:0] d_q, d_d;
    logic [7:0]        cx_q, cx_d;
    logic [6:0]        cy_q, cy_d;
    logic [2:0]        col_q, col_d;
    logic [7:0]        x_hold_q, x_hold_d;
    logic [6:0]        y_hold_q, y_hold_d;

    logic signed [8:0] px;
    logic signed [7:0] py;
    logic              on_screen;
    logic              drawing;

    // One offset register serves as dx in HORIZ and dy in VERT.
    assign px = $signed({1'b0, cx_q}) +
                ((state_q == StHoriz) ? $signed({{5{d_q[3]}}, d_q}) : 9'sd0);
    assign py = $signed({1'b0, cy_q}) +
                ((state_q == StVert) ? $signed({{4{d_q[3]}}, d_q}) : 8'sd0);

    cursor_clip u_clip (
        .x_i         (px),
        .y_i         (py),
        .on_screen_o (on_screen)
    );

    assign drawing = (state_q == StHoriz) || (state_q == StVert);

    always_comb begin
        state_d  = state_q;
        d_d      = d_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        col_d    = col_q;
        x_hold_d = x_hold_q;
        y_hold_d = y_hold_q;

        if (drawing) begin
            x_hold_d = px[7:0];
            y_hold_d = py[6:0];
        end

        unique case (state_q)
            StIdle: begin
                if (go) begin
                    cx_d    = x_in;
                    cy_d    = y_in;
                    col_d   = erase ? BG_COLOUR : colour_in;
                    d_d     = ArmNeg;
                    state_d = StHoriz;
                end
            end
            StHoriz: begin
                if (d_q == ArmPos) begin
                    d_d     = ArmNeg;
                    state_d = StVert;
                end else begin
                    d_d = d_q + 4'sd1;
                end
            end
            StVert: begin
                if (d_q == ArmPos) begin
                    state_d = StDone;
                end else if (d_q == -4'sd1) begin
                    d_d = 4'sd1;
                end else begin
                    d_d = d_q + 4'sd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q  <= StIdle;
            d_q      <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            col_q    <= '0;
            x_hold_q <= '0;
            y_hold_q <= '0;
        end else begin
            state_q  <= state_d;
            d_q      <= d_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            col_q    <= col_d;
            x_hold_q <= x_hold_d;
            y_hold_q <= y_hold_d;
        end
    end

    // Outside the drawing states the last presented pixel is held.
    assign x_VGA   = drawing ? px[7:0] : x_hold_q;
    assign y_VGA   = drawing ? py[6:0] : y_hold_q;
    assign colour  = col_q;
    assign writeEn = drawing && on_screen;
    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);

endmodule

// File: tb/tb_cursor_plotter.sv
// Directed bench for cursor_plotter at ARM=2 with a non-zero erase colour.
module tb_cursor_plotter;

    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b0;
    logic       go = 1'b0;
    logic       erase = 1'b0;
    logic [7:0] x_in = '0;
    logic [6:0] y_in = '0;
    logic [2:0] colour_in = '0;
    logic [7:0] x_VGA;
    logic [6:0] y_VGA;
    logic [2:0] colour;
    logic       writeEn;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    // Offsets presented in drawing cycles 1..9 for ARM=2.
    int dxt [9] = '{-2, -1, 0, 1, 2, 0, 0, 0, 0};
    int dyt [9] = '{0, 0, 0, 0, 0, -2, -1, 1, 2};

    cursor_plotter #(
        .ARM       (2),
        .BG_COLOUR (3'b101)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .go        (go),
        .erase     (erase),
        .x_in      (x_in),
        .y_in      (y_in),
        .colour_in (colour_in),
        .x_VGA     (x_VGA),
        .y_VGA     (y_VGA),
        .colour    (colour),
        .writeEn   (writeEn),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " writeEn"}, 32'(writeEn), 0);
        check({tag, " done"}, 32'(done), 0);
    endtask

    // Called at a negedge; issues go and checks the 10 busy cycles that follow.
    task automatic draw(input logic [7:0] cx, input logic [6:0] cy, input logic [2:0] col,
                        input logic er, input logic [2:0] exp_col, input int exp_writes,
                        input bit go_again);
        int nw;
        int ex;
        int ey;
        bit on;
        nw = 0;
        go = 1'b1;
        x_in = cx;
        y_in = cy;
        colour_in = col;
        erase = er;
        @(negedge CLOCK_50);
        go = 1'b0;
        x_in = 8'h55;
        y_in = 7'h2a;
        colour_in = ~col;
        erase = ~er;
        for (int k = 1; k <= 10; k++) begin
            check($sformatf("busy c%0d", k), 32'(busy), 1);
            check($sformatf("done c%0d", k), 32'(done), (k == 10) ? 1 : 0);
            if (k <= 9) begin
                ex = int'(cx) + dxt[k-1];
                ey = int'(cy) + dyt[k-1];
                on = (ex >= 0) && (ex < 160) && (ey >= 0) && (ey < 120);
                check($sformatf("writeEn c%0d", k), 32'(writeEn), 32'(on));
                if (on) begin
                    check($sformatf("x c%0d", k), 32'(x_VGA), 32'(ex));
                    check($sformatf("y c%0d", k), 32'(y_VGA), 32'(ey));
                    check($sformatf("colour c%0d", k), 32'(colour), 32'(exp_col));
                end
            end else begin
                check("writeEn in done", 32'(writeEn), 0);
            end
            if (writeEn) nw++;
            go = go_again && (k == 3 || k == 10);
            @(negedge CLOCK_50);
        end
        go = 1'b0;
        check_idle("after draw");
        check("write count", 32'(nw), 32'(exp_writes));
        @(negedge CLOCK_50);
        check_idle("idle settle");
    endtask

    initial begin
        resetn = 1'b0;
        go = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        check_idle("reset");
        check("reset x", 32'(x_VGA), 0);
        check("reset y", 32'(y_VGA), 0);
        check("reset colour", 32'(colour), 0);
        resetn = 1'b1;
        go = 1'b0;
        @(negedge CLOCK_50);
        check_idle("post reset");

        draw(8'd80, 7'd60, 3'b100, 1'b0, 3'b100, 9, 1'b0);
        check("hold x", 32'(x_VGA), 80);
        check("hold y", 32'(y_VGA), 62);
        check("hold colour", 32'(colour), 32'(3'b100));

        draw(8'd0, 7'd0, 3'b010, 1'b0, 3'b010, 5, 1'b0);
        draw(8'd159, 7'd119, 3'b011, 1'b1, 3'b101, 5, 1'b0);
        draw(8'd40, 7'd30, 3'b110, 1'b0, 3'b110, 9, 1'b1);
        draw(8'd200, 7'd125, 3'b001, 1'b0, 3'b001, 0, 1'b0);

        // Reset during the 2nd VERT cycle (cycle 7 after acceptance).
        go = 1'b1;
        x_in = 8'd80;
        y_in = 7'd60;
        colour_in = 3'b010;
        erase = 1'b0;
        @(negedge CLOCK_50);
        go = 1'b0;
        repeat (6) @(negedge CLOCK_50);
        check("pre-reset busy", 32'(busy), 1);
        check("pre-reset y", 32'(y_VGA), 59);
        resetn = 1'b0;
        go = 1'b1;
        @(negedge CLOCK_50);
        check_idle("mid reset");
        check("mid reset x", 32'(x_VGA), 0);
        check("mid reset y", 32'(y_VGA), 0);
        check("mid reset colour", 32'(colour), 0);
        resetn = 1'b1;
        go = 1'b0;
        repeat (3) begin
            @(negedge CLOCK_50);
            check_idle("after reset");
        end

        draw(8'd10, 7'd10, 3'b111, 1'b0, 3'b111, 9, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cursor_plotter.md
CURSOR_PLOTTER -- requirements
Module: cursor_plotter

Interface
REQ-001 Parameter ARM, default 2: crosshair arm length in pixels, range 1..7.
REQ-002 Parameter BG_COLOUR, default 3'b000: colour used when erasing.
REQ-003 CLOCK_50  input  1: sole clock; all state changes on its rising edge.
REQ-004 resetn  input  1: synchronous, active-low reset.
REQ-005 go  input  1: request to draw one crosshair; sampled only in IDLE.
REQ-006 erase  input  1: when high at go acceptance, pixels use BG_COLOUR instead of colour_in.
REQ-007 x_in  input  8: crosshair centre column, unsigned.
REQ-008 y_in  input  7: crosshair centre row, unsigned.
REQ-009 colour_in  input  3: draw colour.
REQ-010 x_VGA  output  8: pixel column to the VGA adapter.
REQ-011 y_VGA  output  7: pixel row to the VGA adapter.
REQ-012 colour  output  3: pixel colour to the VGA adapter.
REQ-013 writeEn  output  1: pixel write strobe; x_VGA, y_VGA and colour are valid in the same cycle.
REQ-014 busy  output  1: high from the cycle after go acceptance through the DONE cycle inclusive.
REQ-015 done  output  1: single-cycle pulse when the crosshair is complete.

Function
REQ-016 States: IDLE, HORIZ, VERT, DONE; IDLE is the reset state.
REQ-017 IDLE with go=1: latch x_in, y_in and the effective colour (BG_COLOUR if erase, else colour_in), load dx=-ARM, and enter HORIZ.
REQ-018 HORIZ: lasts 2*ARM+1 cycles with dx stepping -ARM..+ARM; present (cx+dx, cy); after dx=+ARM, enter VERT with dy=-ARM.
REQ-019 VERT: lasts 2*ARM cycles with dy stepping -ARM..+ARM, skipping 0; present (cx, cy+dy); after the last dy, enter DONE.
REQ-020 DONE: lasts 1 cycle; done=1; then enter IDLE.
REQ-021 Total busy time is 4*ARM+2 cycles (10 at ARM=2); the first pixel appears in the cycle immediately after the go acceptance edge.
REQ-022 Pixel coordinates are computed in signed 9-bit (x) and 8-bit (y) arithmetic.
REQ-023 writeEn=1 only in HORIZ or VERT and only when 0<=x<=159 and 0<=y<=119; off-screen pixels consume their cycle with writeEn=0 (clipping, no wrap-around).
REQ-024 A centre outside the screen (x_in>=160 or y_in>=120) is legal and is clipped per pixel.
REQ-025 go while busy, including in DONE, is ignored and not queued.
REQ-026 Input changes after acceptance do not affect the crosshair in progress.
REQ-027 writeEn, done and busy are 0 in IDLE; x_VGA, y_VGA and colour hold their last values in IDLE.

Reset
REQ-028 resetn=0 at any edge, including mid-draw: state becomes IDLE; writeEn, done and busy become 0; x_VGA, y_VGA and colour become 0; latched centre and colour are cleared; the draw in progress is abandoned with no further writes.
REQ-029 go asserted in the same cycle as resetn=0 is ignored.

Structure
REQ-030 A shared package cursor_pkg holds SCREEN_W=160, SCREEN_H=120, the state encoding constants and the default BG_COLOUR.
REQ-031 One sub-module is permitted: cursor_clip, a combinational bounds check taking signed x/y and returning on_screen.

Verification
REQ-032 Centre (80,60), colour 3'b100, ARM=2: 9 writes — (78..82,60), then (80,58),(80,59),(80,61),(80,62) — then a done pulse 10 cycles after acceptance.
REQ-033 Centre (0,0): exactly 5 writes — (0,0),(1,0),(2,0),(0,1),(0,2) — with writeEn=0 in the 4 clipped cycles; busy still lasts 10 cycles.
REQ-034 Centre (159,119) with erase=1: 5 writes, all with colour=BG_COLOUR — (157..159,119),(159,117),(159,118).
REQ-035 go pulsed again in the 3rd HORIZ cycle and again in DONE: no extra writes; exactly one done pulse.
REQ-036 resetn=0 in the 2nd VERT cycle: the next cycle has writeEn=0, busy=0 and all outputs 0; a following go at (10,10) draws a complete, correct crosshair.
